// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// synchronous flush-to-bubble and a saturating stall-cycle counter.
// Optional feature macro: PIPE_STAGE_SKID_EN adds a second (skid) entry so
// that in_ready is registered and does not depend combinationally on
// out_ready. Without the macro the stage is a single entry.
// Whenever out_valid is low, out_data is forced to zero (IR=0 decodes as nop).
module pipe_stage_reg #(
  parameter int DATA_W = 132,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  // Ready comes straight from the skid flop, so there is no path from out_ready.
  assign in_ready = ~skid_valid;

  // Main and skid entries. The skid only ever fills while main is full and
  // stalled, so main is always occupied whenever the skid is occupied.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      if (out_fire) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end
    end else if (in_fire) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end
  end
`else
  // Single entry: accept whenever the slot is empty or being drained.
  assign in_ready = ~out_valid | out_ready;

  // Main entry: flush wins, then load, then drain to a zeroed bubble.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end
  end
`endif

  // Count stalled cycles (including a flush cycle); hold at all-ones.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
